// File: rtl/mem_store_unit_pkg.sv
// Shared CPU definitions for the store path: store-type encodings, byte-enable
// constants and the store-buffer entry layout.
package mem_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } st_type_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE    = 4'b0001;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } sb_entry_t;

endpackage

// File: rtl/store_align.sv
// Combinational store alignment: misalignment detection, byte-enable and
// write-data lane replication for sw/sh/sb.
module store_align
  import mem_store_unit_pkg::*;
(
  input  logic [1:0]  st_type_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic        misaligned_o,
  output logic        reserved_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  byteen_o
);

  always_comb begin
    misaligned_o = 1'b0;
    reserved_o   = 1'b0;
    wdata_o      = st_data_i;
    byteen_o     = BE_NONE;
    case (st_type_e'(st_type_i))
      ST_SW: begin
        misaligned_o = (addr_lo_i != 2'b00);
        byteen_o     = BE_WORD;
      end
      ST_SH: begin
        misaligned_o = addr_lo_i[0];
        byteen_o     = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_o      = {2{st_data_i[15:0]}};
      end
      ST_SB: begin
        byteen_o = BE_BYTE << addr_lo_i;
        wdata_o  = {4{st_data_i[7:0]}};
      end
      default: reserved_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store buffer between the M stage and data memory: aligns stores, queues them
// in a DEPTH-entry FIFO and drains them over a valid/ready write port.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [1:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  output logic        st_exc,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_conflict,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteen,
  output logic        empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  sb_entry_t       mem_q [DEPTH];
  sb_entry_t       mem_d [DEPTH];

  logic        misaligned;
  logic        reserved;
  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_byteen;
  logic        push;
  logic        pop;
  logic        ld_hit;
  sb_entry_t   head;

  logic unused_ld_bits;
  assign unused_ld_bits = ^ld_addr[1:0];

  store_align u_align (
    .st_type_i    (st_type),
    .addr_lo_i    (st_addr[1:0]),
    .st_data_i    (st_data),
    .misaligned_o (misaligned),
    .reserved_o   (reserved),
    .wdata_o      (fmt_wdata),
    .byteen_o     (fmt_byteen)
  );

  assign empty      = (count_q == '0);
  assign st_ready   = (count_q < CntW'(DEPTH));
  assign st_exc     = st_valid & misaligned;
  assign bus_valid  = ~empty;
  assign head       = mem_q[rd_ptr_q];
  assign bus_addr   = {head.waddr, 2'b00};
  assign bus_wdata  = head.wdata;
  assign bus_byteen = empty ? BE_NONE : head.byteen;

  // Faulting and reserved-type stores are dropped without stalling the pipe.
  assign push = st_valid & st_ready & ~misaligned & ~reserved;
  assign pop  = bus_valid & bus_ready;

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{waddr: st_addr[31:2], wdata: fmt_wdata, byteen: fmt_byteen};
    end
  end

  // A slot is live when its distance from the head is below the occupancy; the
  // head being popped this cycle still counts, the store being pushed does not.
  always_comb begin
    logic [PtrW-1:0] off;
    ld_hit = 1'b0;
    off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PtrW'(i) - rd_ptr_q;
      if ((CntW'(off) < count_q) && (mem_q[i].waddr == ld_addr[31:2])) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign ld_conflict = ld_valid & ld_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
